// File: rtl/openofdm_rx_pkg.sv
// Shared types and widths for the receive magnitude path.
package openofdm_rx_pkg;

  localparam int unsigned MAG_SQ_W = 32;
  localparam int unsigned MAG_W    = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mag_sq_to_mag_if.sv
// Strobe-qualified power-in / magnitude-out stream bundle.
interface mag_sq_to_mag_if;
  import openofdm_rx_pkg::*;

  logic [MAG_SQ_W-1:0] mag_sq;
  logic                input_strobe;
  logic [MAG_W-1:0]    mag;
  logic                mag_strobe;

  modport master (output mag_sq, output input_strobe, input mag, input mag_strobe);
  modport slave  (input mag_sq, input input_strobe, output mag, output mag_strobe);
endinterface

// File: rtl/mag_sq_to_mag_sqrt_step.sv
// One combinational restoring square-root iteration: consumes two radicand
// bits and produces the next partial remainder and root.
module sqrt_step #(
  parameter int unsigned ROOT_W = 16
) (
  input  logic [ROOT_W+1:0] rem_i,
  input  logic [ROOT_W-1:0] root_i,
  input  logic [1:0]        bits_i,
  output logic [ROOT_W+1:0] rem_o_c,
  output logic [ROOT_W-1:0] root_o_c
);
  localparam int unsigned REM_W = ROOT_W + 2;

  logic [REM_W-1:0] rem_sh;
  logic [REM_W-1:0] trial;
  logic             ge;

  // Remainder stays below 2*root, so dropping its top bits on the shift is lossless.
  assign rem_sh   = REM_W'({rem_i, bits_i});
  assign trial    = {root_i, 2'b01};
  assign ge       = (rem_sh >= trial);
  assign rem_o_c  = ge ? (rem_sh - trial) : rem_sh;
  assign root_o_c = ROOT_W'({root_i, ge});
endmodule

// File: rtl/mag_sq_to_mag.sv
// Iterative integer square root, one result bit per cycle, with a one-deep
// pending buffer. Define MAG_SQ_TO_MAG_ROUND_EN for round-to-nearest output.
import openofdm_rx_pkg::*;

module mag_sq_to_mag #(
  parameter int unsigned IN_WIDTH = MAG_SQ_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  mag_sq_to_mag_if.slave     bus,
  output logic               busy,
  output logic               overflow
);
  localparam int unsigned OUT_WIDTH = IN_WIDTH / 2;
  localparam int unsigned REM_W     = OUT_WIDTH + 2;
  localparam int unsigned ITER_W    = $clog2(OUT_WIDTH);

  state_e                 state_q, state_d;
  logic [IN_WIDTH-1:0]    radicand_q, radicand_d;
  logic [OUT_WIDTH-1:0]   root_q, root_d;
  logic [REM_W-1:0]       rem_q, rem_d;
  logic [ITER_W-1:0]      iter_q, iter_d;
  logic [IN_WIDTH-1:0]    pend_q, pend_d;
  logic                   pend_vld_q, pend_vld_d;
  logic [OUT_WIDTH-1:0]   mag_q, mag_d;
  logic                   mag_strobe_q, mag_strobe_d;
  logic                   overflow_q, overflow_d;

  logic [REM_W-1:0]       step_rem;
  logic [OUT_WIDTH-1:0]   step_root;
  logic [OUT_WIDTH-1:0]   result_c;

  sqrt_step #(.ROOT_W(OUT_WIDTH)) u_step (
    .rem_i    (rem_q),
    .root_i   (root_q),
    .bits_i   (radicand_q[IN_WIDTH-1 -: 2]),
    .rem_o_c  (step_rem),
    .root_o_c (step_root)
  );

`ifdef MAG_SQ_TO_MAG_ROUND_EN
  // rem > root means sqrt(x) > root + 0.5; saturate at full scale.
  assign result_c = ((rem_q > REM_W'(root_q)) && (root_q != '1))
                    ? root_q + OUT_WIDTH'(1) : root_q;
`else
  assign result_c = root_q;
`endif

  always_comb begin
    state_d      = state_q;
    radicand_d   = radicand_q;
    root_d       = root_q;
    rem_d        = rem_q;
    iter_d       = iter_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    mag_d        = mag_q;
    mag_strobe_d = 1'b0;
    overflow_d   = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (bus.input_strobe) begin
          radicand_d = bus.mag_sq;
          root_d     = '0;
          rem_d      = '0;
          iter_d     = ITER_W'(OUT_WIDTH - 1);
          state_d    = S_CALC;
        end else if (pend_vld_q) begin
          radicand_d = pend_q;
          root_d     = '0;
          rem_d      = '0;
          iter_d     = ITER_W'(OUT_WIDTH - 1);
          pend_vld_d = 1'b0;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        radicand_d = {radicand_q[IN_WIDTH-3:0], 2'b00};
        rem_d      = step_rem;
        root_d     = step_root;
        if (iter_q == '0) state_d = S_DONE;
        else              iter_d  = iter_q - ITER_W'(1);
      end
      S_DONE: begin
        mag_d        = result_c;
        mag_strobe_d = 1'b1;
        state_d      = S_IDLE;
        // Zero-bubble restart from the pending slot.
        if (pend_vld_q) begin
          radicand_d = pend_q;
          root_d     = '0;
          rem_d      = '0;
          iter_d     = ITER_W'(OUT_WIDTH - 1);
          pend_vld_d = 1'b0;
          state_d    = S_CALC;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inputs arriving while busy: oldest pending wins, extras are dropped.
    if ((state_q != S_IDLE) && bus.input_strobe) begin
      if (!pend_vld_q) begin
        pend_d     = bus.mag_sq;
        pend_vld_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      radicand_q   <= '0;
      root_q       <= '0;
      rem_q        <= '0;
      iter_q       <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      mag_q        <= '0;
      mag_strobe_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (enable) begin
      state_q      <= state_d;
      radicand_q   <= radicand_d;
      root_q       <= root_d;
      rem_q        <= rem_d;
      iter_q       <= iter_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      mag_q        <= mag_d;
      mag_strobe_q <= mag_strobe_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.mag        = mag_q;
  assign bus.mag_strobe = mag_strobe_q;
  assign busy           = (state_q != S_IDLE);
  assign overflow       = overflow_q;
endmodule

// File: tb/tb_mag_sq_to_mag.sv
// Directed self-checking bench for mag_sq_to_mag (floor or rounded build).
module tb_mag_sq_to_mag;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b1;
  logic busy, overflow;
  int   n_checks = 0;
  int   n_errors = 0;

  mag_sq_to_mag_if bus ();

  mag_sq_to_mag dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .bus      (bus),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Steps until mag_strobe is seen; lat = steps taken, -1 on timeout.
  task automatic wait_strobe(output int lat);
    int n = 0;
    lat = -1;
    while (lat < 0 && n < 60) begin
      step();
      n++;
      if (bus.mag_strobe) lat = n;
    end
  endtask

  task automatic count_strobes(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (bus.mag_strobe) cnt++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic strobe_in(input logic [31:0] v);
    bus.mag_sq       = v;
    bus.input_strobe = 1'b1;
    step();
    bus.input_strobe = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [31:0] v, input logic [15:0] exp);
    int lat;
    strobe_in(v);
    wait_strobe(lat);
    check({tag, "_lat"}, 32'(lat), 32'd17);
    check({tag, "_mag"}, 32'(bus.mag), 32'(exp));
    step();
    check({tag, "_pulse"}, 32'(bus.mag_strobe), 32'd0);
  endtask

  initial begin
    int lat;
    int cnt;
    logic [15:0] exp24;
    bus.mag_sq       = 32'd123;
    bus.input_strobe = 1'b1;

    // Reset held with strobe asserted
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_mag", 32'(bus.mag), 32'd0);
      check("rst_strobe", 32'(bus.mag_strobe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
    end
    bus.input_strobe = 1'b0;
    reset = 1'b1;
    step();

    run_one("zero", 32'd0, 16'd0);
    run_one("one", 32'd1, 16'd1);
    run_one("million", 32'd1000000, 16'd1000);
    run_one("full", 32'hFFFF_FFFF, 16'hFFFF);
    run_one("sq144", 32'd144, 16'd12);
`ifdef MAG_SQ_TO_MAG_ROUND_EN
    exp24 = 16'd5;
`else
    exp24 = 16'd4;
`endif
    run_one("r24", 32'd24, exp24);
    run_one("r20", 32'd20, 16'd4);
    check("ovf_clean", 32'(overflow), 32'd0);

    // Back-to-back: 100, 49, 9 on consecutive cycles
    bus.input_strobe = 1'b1;
    bus.mag_sq = 32'd100; step();
    bus.mag_sq = 32'd49;  step();
    bus.mag_sq = 32'd9;   step();
    bus.input_strobe = 1'b0;
    check("b2b_ovf", 32'(overflow), 32'd1);
    wait_strobe(lat);
    check("b2b_lat0", 32'(lat), 32'd15);
    check("b2b_mag0", 32'(bus.mag), 32'd10);
    wait_strobe(lat);
    check("b2b_lat1", 32'(lat), 32'd17);
    check("b2b_mag1", 32'(bus.mag), 32'd7);
    count_strobes(40, cnt);
    check("b2b_dropped", 32'(cnt), 32'd0);
    check("b2b_ovf_sticky", 32'(overflow), 32'd1);
    check("b2b_idle", 32'(busy), 32'd0);

    do_reset();
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Enable stall of 5 cycles mid-CALC, strobe during stall ignored
    strobe_in(32'd144);
    repeat (4) step();
    enable = 1'b0;
    bus.mag_sq = 32'd77;
    bus.input_strobe = 1'b1;
    repeat (5) step();
    bus.input_strobe = 1'b0;
    enable = 1'b1;
    wait_strobe(lat);
    check("stall_lat", 32'(lat), 32'd13);
    check("stall_mag", 32'(bus.mag), 32'd12);
    enable = 1'b0;
    step(); step();
    check("stall_stretch", 32'(bus.mag_strobe), 32'd1);
    enable = 1'b1;
    step();
    check("stall_pulse_end", 32'(bus.mag_strobe), 32'd0);
    count_strobes(40, cnt);
    check("stall_no_pend", 32'(cnt), 32'd0);
    check("stall_ovf", 32'(overflow), 32'd0);

    // Reset at iteration 8 with a value pending
    strobe_in(32'd1000000);
    bus.mag_sq = 32'd25;
    bus.input_strobe = 1'b1;
    step();
    bus.input_strobe = 1'b0;
    repeat (6) step();
    do_reset();
    check("midrst_busy", 32'(busy), 32'd0);
    count_strobes(40, cnt);
    check("midrst_no_out", 32'(cnt), 32'd0);
    run_one("after_rst", 32'd4, 16'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
